// File: rtl/display_scan_if.sv
// Scanner bus: display value/controls in, digit/anode/dp/scan status out.
// master drives iData/iDp/iEn/iLzs/iLoad; slave drives oDigit/oAnode/oDp/oIndex/oFrame.
interface display_scan_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] iData;
  logic [NUM_DIGITS-1:0]   iDp;
  logic [NUM_DIGITS-1:0]   iEn;
  logic                    iLzs;
  logic                    iLoad;
  logic [3:0]              oDigit;
  logic [NUM_DIGITS-1:0]   oAnode;
  logic                    oDp;
  logic [IW-1:0]           oIndex;
  logic                    oFrame;

  modport master (
    output iData, iDp, iEn, iLzs, iLoad,
    input  oDigit, oAnode, oDp, oIndex, oFrame
  );

  modport slave (
    input  iData, iDp, iEn, iLzs, iLoad,
    output oDigit, oAnode, oDp, oIndex, oFrame
  );
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed 7-segment scanner with double buffer, blanking and LZS.
// Ports: iClk, iRst_n (sync, active-low), bus (display_scan_if.slave).
module display_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic          iClk,
  input logic          iRst_n,
  display_scan_if.slave bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (BLANK_CYCLES > 0) ?
                      $clog2(BLANK_CYCLES + 1) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_INIT = BW'(BLANK_CYCLES);

  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [BW-1:0]         blk, blk_nx;
  logic [DW-1:0]         act_d, act_d_nx;
  logic [NUM_DIGITS-1:0] act_dp, act_dp_nx;
  logic [DW-1:0]         pnd_d, pnd_d_nx;
  logic [NUM_DIGITS-1:0] pnd_dp, pnd_dp_nx;
  logic                  pnd_v, pnd_v_nx;

  logic                  tick;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] sup;
  logic                  zrun;
  logic                  lit_nx;

  logic [3:0]            digit_nx, digit_q;
  logic [NUM_DIGITS-1:0] anode_nx, anode_q;
  logic                  dp_nx, dp_q;
  logic                  frame_q;

  always_comb begin
    tick = (cnt == CNT_MAX);
    wrap = tick && (idx == IDX_MAX);

    cnt_nx = tick ? '0 : cnt + 1'b1;

    idx_nx = idx;
    if (tick)
      idx_nx = (idx == IDX_MAX) ? '0 : idx + 1'b1;

    blk_nx = blk;
    if (tick)
      blk_nx = BLK_INIT;
    else if (blk != '0)
      blk_nx = blk - 1'b1;

    act_d_nx  = act_d;
    act_dp_nx = act_dp;
    pnd_d_nx  = pnd_d;
    pnd_dp_nx = pnd_dp;
    pnd_v_nx  = pnd_v;

    // Active buffer only moves at a frame boundary so a
    // frame never mixes old and new nibbles.
    if (wrap) begin
      pnd_v_nx = 1'b0;
      if (bus.iLoad) begin
        act_d_nx  = bus.iData;
        act_dp_nx = bus.iDp;
      end else if (pnd_v) begin
        act_d_nx  = pnd_d;
        act_dp_nx = pnd_dp;
      end
    end else if (bus.iLoad) begin
      pnd_d_nx  = bus.iData;
      pnd_dp_nx = bus.iDp;
      pnd_v_nx  = 1'b1;
    end

    // Walk from the most significant nibble down; zrun
    // stays set while every nibble so far is zero.
    sup  = '0;
    zrun = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zrun   = zrun && (act_d_nx[4*k +: 4] == 4'h0);
      sup[k] = bus.iLzs && zrun && (k != 0);
    end

    digit_nx = act_d_nx[4*int'(idx_nx) +: 4];
    lit_nx   = (blk_nx == '0) && bus.iEn[idx_nx]
               && !sup[idx_nx];
    anode_nx = lit_nx ? ~(NUM_DIGITS'(1) << idx_nx) : '1;
    dp_nx    = ~(lit_nx && act_dp_nx[idx_nx]);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cnt     <= '0;
      idx     <= '0;
      blk     <= '0;
      act_d   <= '0;
      act_dp  <= '0;
      pnd_d   <= '0;
      pnd_dp  <= '0;
      pnd_v   <= 1'b0;
      digit_q <= 4'h0;
      anode_q <= '1;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      blk     <= blk_nx;
      act_d   <= act_d_nx;
      act_dp  <= act_dp_nx;
      pnd_d   <= pnd_d_nx;
      pnd_dp  <= pnd_dp_nx;
      pnd_v   <= pnd_v_nx;
      digit_q <= digit_nx;
      anode_q <= anode_nx;
      dp_q    <= dp_nx;
      frame_q <= wrap;
    end
  end

  assign bus.oDigit = digit_q;
  assign bus.oAnode = anode_q;
  assign bus.oDp    = dp_q;
  assign bus.oIndex = idx;
  assign bus.oFrame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan (8 digits, 4-cycle slots, 1 blank).
// Stimulus queues per-cycle expectations; a negedge monitor compares.
module tb_display_scan;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int BLK = 1;

  logic iClk = 1'b0;
  logic iRst_n;

  always #5 iClk = ~iClk;

  display_scan_if #(.NUM_DIGITS(N)) bus ();

  display_scan #(
    .NUM_DIGITS(N),
    .CLK_DIV(DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] anode;
    logic [3:0] digit;
    logic       dp;
    logic [2:0] index;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed cyc%0d: expectation never compared", e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if (bus.oAnode !== e.anode || bus.oDigit !== e.digit ||
          bus.oDp !== e.dp || bus.oIndex !== e.index ||
          bus.oFrame !== e.frame) begin
        errors++;
        $display("FAIL scan cyc%0d: got an=%h dig=%h dp=%b ix=%0d fr=%b, want an=%h dig=%h dp=%b ix=%0d fr=%b",
                 cyc, bus.oAnode, bus.oDigit, bus.oDp, bus.oIndex,
                 bus.oFrame, e.anode, e.digit, e.dp, e.index, e.frame);
      end
    end
  end

  task automatic push(input int c, input logic [7:0] a,
                      input logic [3:0] d, input logic p,
                      input logic [2:0] ix, input logic f);
    exp_t e;
    e.cyc = c; e.anode = a; e.digit = d;
    e.dp = p; e.index = ix; e.frame = f;
    q.push_back(e);
  endtask

  // One slot: first cycle blanked, remaining cycles lit or dark.
  task automatic exp_slot(input int start, input int s,
                          input logic [3:0] d, input logic lit,
                          input logic dpb, input logic f,
                          input int ncyc);
    logic [7:0] on;
    on = 8'h01;
    on = ~(on << s);
    for (int i = 0; i < ncyc; i++) begin
      if (i == 0)
        push(start, 8'hFF, d, 1'b1, 3'(s), f);
      else
        push(start + i, lit ? on : 8'hFF, d,
             !(lit && dpb), 3'(s), 1'b0);
    end
  endtask

  task automatic exp_frame(input int base, input logic [31:0] digs,
                           input logic [7:0] en, input logic [7:0] dpm,
                           input logic [7:0] dark, input int nslots);
    for (int s = 0; s < nslots; s++)
      exp_slot(base + DIV*s, s, digs[4*s +: 4],
               en[s] && !dark[s], dpm[s], s == 0, DIV);
  endtask

  // Reset edge at r, then slot 0 has no blank cycle, slots 1..7
  // show the zeroed reset buffer.
  task automatic exp_after_reset(input int r);
    push(r, 8'hFF, 4'h0, 1'b1, 3'd0, 1'b0);
    for (int c = 1; c < DIV; c++)
      push(r + c, 8'hFE, 4'h0, 1'b1, 3'd0, 1'b0);
    for (int k = 1; k < N; k++)
      exp_slot(r + DIV + DIV*(k-1), k, 4'h0, 1'b1, 1'b0, 1'b0, DIV);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] p,
                      input int at);
    wait_cyc(at - 1);
    bus.iData = d;
    bus.iDp   = p;
    bus.iLoad = 1'b1;
    wait_cyc(at);
    bus.iLoad = 1'b0;
  endtask

  initial begin
    iRst_n    = 1'b0;
    bus.iData = '0;
    bus.iDp   = '0;
    bus.iEn   = 8'hFF;
    bus.iLzs  = 1'b0;
    bus.iLoad = 1'b0;

    push(1, 8'hFF, 4'h0, 1'b1, 3'd0, 1'b0);
    push(2, 8'hFF, 4'h0, 1'b1, 3'd0, 1'b0);
    exp_after_reset(3);
    exp_frame(35, 32'h76543210, 8'hFF, 8'h00, 8'h00, 8);
    exp_frame(67, 32'h76543210, 8'hFF, 8'h00, 8'h00, 8);

    wait_cyc(3);
    iRst_n = 1'b1;
    load(32'h76543210, 8'h00, 4);

    load(32'hDEADBEEF, 8'h00, 80);
    exp_frame(99, 32'hDEADBEEF, 8'hFF, 8'h00, 8'h00, 8);

    load(32'hCAFEBABE, 8'h00, 110);
    exp_frame(131, 32'h11111111, 8'hFF, 8'h00, 8'h00, 8);
    exp_frame(163, 32'h11111111, 8'hFF, 8'h00, 8'h00, 8);
    load(32'h11111111, 8'h00, 131);

    load(32'h00000105, 8'h00, 170);
    exp_frame(195, 32'h00000105, 8'hFF, 8'h00, 8'hF8, 8);
    wait_cyc(194);
    bus.iLzs = 1'b1;

    load(32'h00000000, 8'h00, 200);
    exp_frame(227, 32'h00000000, 8'hFF, 8'h00, 8'hFE, 8);

    load(32'h89ABCDEF, 8'h04, 240);
    exp_frame(259, 32'h89ABCDEF, 8'h0F, 8'h04, 8'h00, 8);
    exp_frame(291, 32'h89ABCDEF, 8'h0F, 8'h04, 8'h00, 5);
    exp_slot(311, 5, 4'hA, 1'b0, 1'b0, 1'b0, 2);
    wait_cyc(258);
    bus.iLzs = 1'b0;
    bus.iEn  = 8'h0F;

    load(32'h55555555, 8'hFF, 295);
    exp_after_reset(313);
    exp_frame(345, 32'h00000000, 8'hFF, 8'h00, 8'h00, 8);

    wait_cyc(312);
    iRst_n = 1'b0;
    wait_cyc(313);
    iRst_n  = 1'b1;
    bus.iEn = 8'hFF;
    bus.iDp = 8'h00;

    wait_cyc(380);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
